// File: rtl/ram_pkg.sv
// Shared types for the RAM command scheduler: default widths, command and
// response records, and the scheduler FSM state.
package ram_pkg;

  localparam int RAM_ADDR_W = 32;
  localparam int RAM_DATA_W = 32;

  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_cmd_t;

  typedef struct packed {
    logic [RAM_DATA_W-1:0] data;
    logic                  err;
  } ram_rsp_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

endpackage

// File: rtl/ram_sched_fifo.sv
// Synchronous FIFO with a clear input; full/empty come from an extra pointer MSB.
// Push while full is accepted only when a pop happens in the same cycle.
module ram_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ram_cmd_sched.sv
// In-order read/write command scheduler in front of the ram block, with credit-limited reads.
// Optional address range check enabled by defining RAM_SCHED_RANGE_CHK_EN.
module ram_cmd_sched
  import ram_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int DEPTH     = 4,
  parameter int RD_LAT    = 1,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  sched_state_t      state;
  cmd_t              cmd_in;
  cmd_t              cmd_head;
  rsp_t              rsp_in;
  rsp_t              rsp_head;
  logic              cmd_full;
  logic              cmd_empty;
  logic              rsp_full;
  logic              rsp_empty;
  logic [CNT_W-1:0]  cmd_count;
  logic [CNT_W-1:0]  rsp_count;
  logic              cmd_push;
  logic              flush_go;
  logic              issue;
  logic              head_oor;
  logic              rd_credit;
  logic              bypass_q;
  logic [RD_LAT-1:0] sr_v;
  logic [RD_LAT-1:0] sr_e;
  logic              rsp_push;
  logic              rsp_pop;
  int                inflight;
  logic              unused;

  assign cmd_ready = !cmd_full && (state == RUN) && !rst;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_in    = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
  assign flush_go  = flush && (state == RUN);

  ram_sched_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_q (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_go),
    .push  (cmd_push),
    .din   (cmd_in),
    .pop   (issue),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

`ifdef RAM_SCHED_RANGE_CHK_EN
  assign head_oor = (cmd_head.addr >= ADDR_W'(MEM_WORDS));
  assign unused   = ^{cmd_count, rsp_full};
`else
  assign head_oor = 1'b0;
  assign unused   = ^{cmd_count, rsp_full, MEM_WORDS};
`endif

  // Reads still in the RAM pipe (including the one on the port this cycle) hold a credit.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    inflight = int'(ram_rd_en) + int'(bypass_q);
    for (int i = 0; i < RD_LAT; i++) inflight += int'(sr_v[i]);
  end

  assign rd_credit = (int'(rsp_count) + inflight) < DEPTH;
  assign issue     = !cmd_empty && (state == RUN) && !flush && (cmd_head.we || rd_credit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      bypass_q    <= 1'b0;
    end else begin
      ram_wr_en <= issue && cmd_head.we && !head_oor;
      ram_rd_en <= issue && !cmd_head.we && !head_oor;
      bypass_q  <= issue && !cmd_head.we && head_oor;
      if (issue && cmd_head.we) begin
        ram_wr_addr <= cmd_head.addr;
        ram_wr_data <= cmd_head.wdata;
      end
      if (issue && !cmd_head.we) ram_rd_addr <= cmd_head.addr;
      case (state)
        RUN:     if (flush) state <= DRAIN;
        DRAIN:   if (inflight == 0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Out-of-range reads ride the same pipe as real ones so they land at the same latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_v <= '0;
      sr_e <= '0;
    end else begin
      sr_v[0] <= ram_rd_en || bypass_q;
      sr_e[0] <= bypass_q;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_e[i] <= sr_e[i-1];
      end
    end
  end

  assign rsp_push = sr_v[RD_LAT-1];
  assign rsp_in   = '{data: (sr_e[RD_LAT-1] ? '0 : ram_rd_data), err: sr_e[RD_LAT-1]};
  assign rsp_pop  = rsp_valid && rsp_ready;

  ram_sched_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) u_rsp_q (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (rsp_push),
    .din   (rsp_in),
    .pop   (rsp_pop),
    .dout  (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  assign rsp_valid = !rsp_empty;
  assign rsp_data  = rsp_valid ? rsp_head.data : '0;
  assign rsp_err   = rsp_valid && rsp_head.err;

endmodule
